pc_unit: RTL and testbench

//  Next-generation fetch PC unit: owns the PC register and computes the next PC for seq/branch/j/jal/jr.

---
 rtl/pc_pkg.sv | 16 +
 rtl/pc_unit_if.sv | 47 ++++
 rtl/ret_addr_stack.sv | 80 ++++++++
 rtl/pc_unit.sv | 126 ++++++++++++
 tb/tb_pc_unit.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/pc_pkg.sv
// Package: pc_pkg
// Purpose: constants shared by the fetch PC unit, its return-address stack
//          and the control logic that drives it.
//   PC_SEL_*      encodings of the pc_sel field (11 is reserved and behaves as SEQ)
//   DEF_RESET_PC  default PC loaded on reset
//   DEF_EXC_VEC   default exception vector
package pc_pkg;

    localparam logic [1:0] PC_SEL_SEQ = 2'b00;
    localparam logic [1:0] PC_SEL_JMP = 2'b01;
    localparam logic [1:0] PC_SEL_JR  = 2'b10;

    localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
    localparam logic [31:0] DEF_EXC_VEC  = 32'h0000_4180;

endpackage

// File: rtl/pc_unit_if.sv
// Interface: pc_unit_if
// Purpose: bundles the control inputs and PC/RAS status outputs of pc_unit.
//   master modport: decode/execute control side (drives control, sees PC state)
//   slave  modport: pc_unit itself
// Signals:
//   stall, pc_sel[1:0], br_en, zero, imm[25:0], reg_data[AW-1:0],
//   is_call, is_ret, exc_req, eret                       (control -> pc_unit)
//   pc, pc_4, npc, epc [AW-1:0], ret_hit, ret_miss,
//   ras_empty, miss_cnt[CNT_W-1:0]                       (pc_unit -> control)
interface pc_unit_if #(
    parameter int AW    = 32,
    parameter int CNT_W = 16
);

    logic             stall;
    logic [1:0]       pc_sel;
    logic             br_en;
    logic             zero;
    logic [25:0]      imm;
    logic [AW-1:0]    reg_data;
    logic             is_call;
    logic             is_ret;
    logic             exc_req;
    logic             eret;

    logic [AW-1:0]    pc;
    logic [AW-1:0]    pc_4;
    logic [AW-1:0]    npc;
    logic [AW-1:0]    epc;
    logic             ret_hit;
    logic             ret_miss;
    logic             ras_empty;
    logic [CNT_W-1:0] miss_cnt;

    modport master (
        output stall, pc_sel, br_en, zero, imm, reg_data,
               is_call, is_ret, exc_req, eret,
        input  pc, pc_4, npc, epc, ret_hit, ret_miss, ras_empty, miss_cnt
    );

    modport slave (
        input  stall, pc_sel, br_en, zero, imm, reg_data,
               is_call, is_ret, exc_req, eret,
        output pc, pc_4, npc, epc, ret_hit, ret_miss, ras_empty, miss_cnt
    );

endinterface

// File: rtl/ret_addr_stack.sv
// Module: ret_addr_stack
// Purpose: circular return-address stack. When full, a push overwrites the
//          oldest entry and occupancy stays at RAS_DEPTH. A pop on an empty
//          stack is ignored. Push together with a (non-empty) pop replaces
//          the top entry in place.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   push, push_data push request and the address to store
//   pop             pop request
//   top             current top entry (valid only when !empty)
//   empty           no entries held
module ret_addr_stack #(
    parameter int AW        = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [AW-1:0] push_data,
    output logic [AW-1:0] top,
    output logic          empty
);

    localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CW    = $clog2(RAS_DEPTH + 1);

    logic [AW-1:0]    mem [RAS_DEPTH];
    logic [PTR_W-1:0] top_ptr_q, top_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full;
    logic             do_pop;
    logic             we;
    logic [PTR_W-1:0] waddr;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(RAS_DEPTH));
    assign top   = mem[top_ptr_q];

    always_comb begin
        do_pop    = pop && !empty;
        top_ptr_d = top_ptr_q;
        count_d   = count_q;
        we        = 1'b0;
        waddr     = top_ptr_q;
        if (push && do_pop) begin
            // pop then push: net effect is replacing the top entry
            we = 1'b1;
        end else if (push) begin
            // pointer wraps naturally, so a full stack loses its oldest entry
            we        = 1'b1;
            waddr     = top_ptr_q + PTR_W'(1);
            top_ptr_d = waddr;
            if (!full) begin
                count_d = count_q + CW'(1);
            end
        end else if (do_pop) begin
            top_ptr_d = top_ptr_q - PTR_W'(1);
            count_d   = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            top_ptr_q <= '0;
            count_q   <= '0;
        end else begin
            top_ptr_q <= top_ptr_d;
            count_q   <= count_d;
        end
    end

    // Storage needs no reset: entries are only read while count_q says valid.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= push_data;
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Module: pc_unit
// Purpose: fetch PC unit. Owns the PC and EPC registers, computes the next PC
//          (exception > eret > taken branch > j/jal > jr > sequential), and
//          checks jr-$31 targets against a return-address stack, pulsing
//          ret_hit/ret_miss one cycle later and counting misses (saturating).
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   bus         pc_unit_if.slave: control inputs and PC/RAS status outputs
module pc_unit
    import pc_pkg::*;
#(
    parameter int          AW        = 32,
    parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
    parameter logic [31:0] EXC_VEC   = DEF_EXC_VEC,
    parameter int          RAS_DEPTH = 4,
    parameter int          CNT_W     = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    pc_unit_if.slave   bus
);

    localparam logic [AW-1:0] RESET_PC_A = AW'(RESET_PC);
    localparam logic [AW-1:0] EXC_VEC_A  = AW'(EXC_VEC);

    logic [AW-1:0]    pc_q, pc_d;
    logic [AW-1:0]    epc_q, epc_d;
    logic             ret_hit_q, ret_hit_d;
    logic             ret_miss_q, ret_miss_d;
    logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;

    logic [AW-1:0]    pc_plus4;
    logic [AW-1:0]    br_off;
    logic [AW-1:0]    npc;
    logic             accepted;
    logic             ras_push;
    logic             ras_pop;
    logic             ras_empty;
    logic [AW-1:0]    ras_top;

    ret_addr_stack #(
        .AW        (AW),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (pc_plus4),
        .top       (ras_top),
        .empty     (ras_empty)
    );

    // Next-PC mux; all sums wrap modulo 2^AW.
    always_comb begin
        pc_plus4 = pc_q + AW'(4);
        br_off   = {{(AW-18){bus.imm[15]}}, bus.imm[15:0], 2'b00};
        npc      = pc_plus4;
        if (bus.exc_req) begin
            npc = EXC_VEC_A;
        end else if (bus.eret) begin
            npc = epc_q;
        end else if (bus.br_en && bus.zero) begin
            npc = pc_plus4 + br_off;
        end else begin
            case (bus.pc_sel)
                PC_SEL_SEQ: npc = pc_plus4;
                PC_SEL_JMP: npc = {pc_q[AW-1:28], bus.imm, 2'b00};
                PC_SEL_JR:  npc = bus.reg_data;
                default:    npc = pc_plus4;
            endcase
        end
    end

    always_comb begin
        // Only an instruction that actually retires this cycle touches the RAS.
        accepted = !bus.stall && !bus.exc_req;
        ras_pop  = accepted && bus.is_ret;
        ras_push = accepted && bus.is_call;

        pc_d  = pc_q;
        epc_d = epc_q;
        if (bus.exc_req) begin
            // exception overrides stall and eret
            pc_d  = EXC_VEC_A;
            epc_d = pc_q;
        end else if (!bus.stall) begin
            pc_d = npc;
        end

        ret_hit_d  = ras_pop && !ras_empty && (ras_top == bus.reg_data);
        ret_miss_d = ras_pop && (ras_empty || (ras_top != bus.reg_data));

        // Counter advances on the same edge that raises ret_miss.
        miss_cnt_d = miss_cnt_q;
        if (ret_miss_d && (miss_cnt_q != '1)) begin
            miss_cnt_d = miss_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC_A;
            epc_q      <= '0;
            ret_hit_q  <= 1'b0;
            ret_miss_q <= 1'b0;
            miss_cnt_q <= '0;
        end else begin
            pc_q       <= pc_d;
            epc_q      <= epc_d;
            ret_hit_q  <= ret_hit_d;
            ret_miss_q <= ret_miss_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign bus.pc        = pc_q;
    assign bus.pc_4      = pc_plus4;
    assign bus.npc       = npc;
    assign bus.epc       = epc_q;
    assign bus.ret_hit   = ret_hit_q;
    assign bus.ret_miss  = ret_miss_q;
    assign bus.ras_empty = ras_empty;
    assign bus.miss_cnt  = miss_cnt_q;

endmodule

// File: tb/tb_pc_unit.sv
// Testbench for pc_unit: a behavioural reference model (PC/EPC plus a queue
// as the return-address stack) predicts state; return-check outcomes are
// pushed to a scoreboard queue when a return is driven and popped when the
// hit/miss pulse is due.
module tb_pc_unit;

    localparam int          AW    = 32;
    localparam int          CNT_W = 3;
    localparam int          DEPTH = 4;
    localparam logic [31:0] RST   = 32'h0000_3000;
    localparam logic [31:0] EXC   = 32'h0000_4180;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pc_unit_if #(.AW(AW), .CNT_W(CNT_W)) bus ();

    pc_unit #(
        .AW        (AW),
        .RESET_PC  (RST),
        .EXC_VEC   (EXC),
        .RAS_DEPTH (DEPTH),
        .CNT_W     (CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int n_txn    = 0;

    logic [31:0]      m_pc;
    logic [31:0]      m_epc;
    logic [31:0]      m_ras[$];
    logic [1:0]       sb[$];      // expected {ret_hit, ret_miss}
    logic [CNT_W-1:0] m_miss;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pc   = RST;
        m_epc  = 32'h0;
        m_miss = '0;
        m_ras.delete();
        sb.delete();
    endtask

    task automatic post_check();
        logic [1:0] exp_p;
        check("pc", bus.pc, m_pc);
        check("epc", bus.epc, m_epc);
        check("ras_empty", 32'(bus.ras_empty), 32'(m_ras.size() == 0));
        check("miss_cnt", 32'(bus.miss_cnt), 32'(m_miss));
        if (bus.ret_hit || bus.ret_miss || sb.size() != 0) begin
            exp_p = (sb.size() != 0) ? sb.pop_front() : 2'b00;
            check("ret_pulse", 32'({bus.ret_hit, bus.ret_miss}), 32'(exp_p));
        end
    endtask

    task automatic drive(input logic st, input logic [1:0] sel, input logic be, input logic z,
                         input logic [25:0] im, input logic [31:0] rd, input logic call,
                         input logic ret, input logic exc, input logic er);
        logic [31:0] exp_npc;
        logic [31:0] top;
        logic [1:0]  hm;
        bus.stall    = st;
        bus.pc_sel   = sel;
        bus.br_en    = be;
        bus.zero     = z;
        bus.imm      = im;
        bus.reg_data = rd;
        bus.is_call  = call;
        bus.is_ret   = ret;
        bus.exc_req  = exc;
        bus.eret     = er;
        #1;
        if (exc)            exp_npc = EXC;
        else if (er)        exp_npc = m_epc;
        else if (be && z)   exp_npc = m_pc + 32'd4 + {{14{im[15]}}, im[15:0], 2'b00};
        else if (sel == 2'b01) exp_npc = {m_pc[31:28], im, 2'b00};
        else if (sel == 2'b10) exp_npc = rd;
        else                exp_npc = m_pc + 32'd4;
        check("npc", bus.npc, exp_npc);
        check("pc_4", bus.pc_4, m_pc + 32'd4);
        if (!st && !exc && ret) begin
            if (m_ras.size() == 0) begin
                hm = 2'b01;
            end else begin
                top = m_ras.pop_back();
                hm  = (top == rd) ? 2'b10 : 2'b01;
            end
            sb.push_back(hm);
            if (hm[0] && (m_miss != '1)) m_miss++;
        end
        if (!st && !exc && call) begin
            m_ras.push_back(m_pc + 32'd4);
            if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
        end
        if (exc) begin
            m_epc = m_pc;
            m_pc  = EXC;
        end else if (!st) begin
            m_pc = exp_npc;
        end
        @(posedge clk);
        #1;
        post_check();
        n_txn++;
        $display("txn %0d: pc=0x%08h epc=0x%08h hit=%0b miss=%0b miss_cnt=%0d ras_empty=%0b",
                 n_txn, bus.pc, bus.epc, bus.ret_hit, bus.ret_miss, bus.miss_cnt, bus.ras_empty);
    endtask

    task automatic idle();
        drive(1'b0, 2'b00, 1'b0, 1'b0, 26'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic jmp(input logic [25:0] im, input logic call);
        drive(1'b0, 2'b01, 1'b0, 1'b0, im, 32'h0, call, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic jr(input logic [31:0] rd, input logic ret);
        drive(1'b0, 2'b10, 1'b0, 1'b0, 26'h0, rd, 1'b0, ret, 1'b0, 1'b0);
    endtask

    task automatic reset_state_check();
        check("rst_pc", bus.pc, RST);
        check("rst_epc", bus.epc, 32'h0);
        check("rst_ras_empty", 32'(bus.ras_empty), 32'd1);
        check("rst_miss_cnt", 32'(bus.miss_cnt), 32'd0);
        check("rst_pulses", 32'({bus.ret_hit, bus.ret_miss}), 32'd0);
    endtask

    task automatic set_idle_inputs();
        bus.stall = 1'b0; bus.pc_sel = 2'b00; bus.br_en = 1'b0; bus.zero = 1'b0;
        bus.imm = 26'h0; bus.reg_data = 32'h0; bus.is_call = 1'b0; bus.is_ret = 1'b0;
        bus.exc_req = 1'b0; bus.eret = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        set_idle_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset_state_check();
        @(negedge clk);
        rst_n = 1'b1;

        // sequential fetch
        repeat (4) idle();                                  // 3004..3010

        // branch: stalled so npc can be inspected with the PC held at 0x3010
        drive(1'b1, 2'b00, 1'b1, 1'b1, 26'hFFFE, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0); // npc 300C
        drive(1'b1, 2'b00, 1'b1, 1'b0, 26'hFFFE, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0); // npc 3014
        drive(1'b0, 2'b00, 1'b1, 1'b1, 26'hFFFE, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0); // pc 300C

        // jal / jr $31 hit
        jmp(26'h0C00, 1'b0);                                // pc 3000
        jmp(26'h0C10, 1'b1);                                // pc 3040, push 3004
        jr(32'h3004, 1'b1);                                 // hit
        jr(32'h3008, 1'b1);                                 // empty -> miss
        jmp(26'h0C10, 1'b1);                                // push 300C
        jr(32'h3008, 1'b1);                                 // mismatch -> miss

        // stalled call must not push
        drive(1'b1, 2'b01, 1'b0, 1'b0, 26'h0C10, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);

        // 5 calls overflow a depth-4 stack; 5 returns: 4 hits then empty miss
        for (int k = 0; k < 5; k++) jmp(26'h0C40 + 26'(k * 8), 1'b1);
        for (int k = 0; k < 5; k++) begin
            rd = (m_ras.size() != 0) ? m_ras[m_ras.size() - 1] : 32'h0000_3000;
            jr(rd, 1'b1);
        end

        // call and return in the same instruction: top replaced
        jmp(26'h0C00, 1'b1);                                // push pc+4
        rd = m_ras[m_ras.size() - 1];
        drive(1'b0, 2'b10, 1'b0, 1'b0, 26'h0, rd, 1'b1, 1'b1, 1'b0, 1'b0);
        rd = m_ras[m_ras.size() - 1];
        jr(rd, 1'b1);

        // wrap at the top of the address space
        jr(32'hFFFF_FFFC, 1'b0);
        idle();                                             // pc 0
        jmp(26'h0C08, 1'b0);                                // pc 3020

        // exception under stall (return ignored), then eret
        drive(1'b1, 2'b00, 1'b0, 1'b0, 26'h0, 32'h3020, 1'b0, 1'b1, 1'b1, 1'b0);
        idle();
        drive(1'b0, 2'b00, 1'b0, 1'b0, 26'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1); // pc 3020
        idle();
        drive(1'b0, 2'b00, 1'b0, 1'b0, 26'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1); // exc wins

        // drive the miss counter into saturation
        for (int k = 0; k < 6; k++) jr(32'h0000_3000, 1'b1);
        jmp(26'h0C00, 1'b1);

        // asynchronous reset in the middle of a cycle
        set_idle_inputs();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        reset_state_check();
        @(posedge clk);
        #1;
        reset_state_check();
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        idle();

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
